// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI leader transmitter and follower receiver.
//   DEFAULT_DATA_LENGTH : default word width for both ends of the link
//   SCK_DIV_TC          : leader sck divider terminal count (half-period = TC+1 clk)
//   rx_state_t          : follower receiver state encoding (ARM / IDLE / RECV)
package spi_pkg;

  localparam int DEFAULT_DATA_LENGTH = 8;
  localparam int SCK_DIV_TC          = 24;

  localparam logic [1:0] ST_ARM_ENC  = 2'd0;
  localparam logic [1:0] ST_IDLE_ENC = 2'd1;
  localparam logic [1:0] ST_RECV_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_ARM  = ST_ARM_ENC,
    ST_IDLE = ST_IDLE_ENC,
    ST_RECV = ST_RECV_ENC
  } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: SYNC_STAGES-deep single-bit synchronizer for an asynchronous input.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RESET_VAL into every stage
//   d   : asynchronous input
//   q   : synchronized output (SYNC_STAGES clk of delay)
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic [SYNC_STAGES-1:0] stage_next;

  assign stage_next[0] = d;

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_follower_receiver.sv
// spi_follower_receiver: follower-side SPI receiver, oversampled in the clk domain.
// Frames words on active-low ss, shifts mosi MSB-first on rising sck.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   sck/ss/mosi : asynchronous SPI lines from the leader
//   rx_data   : last completed word, held until the next one completes
//   rx_valid  : one-cycle strobe, rx_data is new this cycle
//   frame_err : one-cycle strobe, ss released mid-word
//   rx_busy   : high while receiving (synchronized ss low)
module spi_follower_receiver
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   mosi,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int                CNT_W    = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_LENGTH - 1);
  localparam int                ARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES);

  logic sck_s, ss_s, mosi_s;
  logic sck_d_reg;
  logic rise;

  rx_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [DATA_LENGTH-1:0] shift_reg, shift_next;
  logic [DATA_LENGTH-1:0] rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   frame_err_reg, frame_err_next;
  logic [ARM_W-1:0]       arm_cnt_reg, arm_cnt_next;
  logic [DATA_LENGTH-1:0] shift_in;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  assign rise     = sck_s & ~sck_d_reg;
  assign shift_in = {shift_reg[DATA_LENGTH-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_d_reg     <= 1'b0;
      state_reg     <= ST_ARM;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      arm_cnt_reg   <= '0;
    end else begin
      sck_d_reg     <= sck_s;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      arm_cnt_reg   <= arm_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    arm_cnt_next   = arm_cnt_reg;
    case (state_reg)
      ST_ARM: begin
        // The ss synchronizer resets to 1, so its output is not a real sample
        // of the line until the pipeline has refilled. Wait that out before
        // trusting ss_s high, otherwise a reset mid-frame would rejoin it.
        if (arm_cnt_reg != ARM_DONE) begin
          arm_cnt_next = arm_cnt_reg + ARM_W'(1);
        end else if (ss_s) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!ss_s) begin
          state_next = ST_RECV;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_RECV: begin
        // ss release takes priority over a coincident sck rise.
        if (ss_s) begin
          state_next     = ST_IDLE;
          frame_err_next = (cnt_reg != '0);
        end else if (rise) begin
          shift_next = shift_in;
          if (cnt_reg == CNT_LAST) begin
            rx_data_next  = shift_in;
            rx_valid_next = 1'b1;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_ARM;
      end
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg == ST_RECV);

endmodule

// File: tb/tb_spi_follower_receiver.sv
// Bench for spi_follower_receiver: a leader model drives sck/ss/mosi at the
// leader's half-period; expected words are queued when driven and popped when
// rx_valid is seen.
module tb_spi_follower_receiver;
  import spi_pkg::*;

  localparam int HALF = SCK_DIV_TC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         err_seen = 0;
  int         err_exp  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  spi_follower_receiver #(.DATA_LENGTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: one line per received word or error pulse.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          $display("rx word %02h with no word outstanding", rx_data);
          check("rx_valid_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("rx word %02h, expected %02h", rx_data, mon_exp);
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
        end
      end
      if (frame_err === 1'b1) begin
        err_seen++;
        $display("frame_err pulse #%0d", err_seen);
      end
      if (rx_valid === 1'b1 && frame_err === 1'b1) begin
        check("valid_err_overlap", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leader changes mosi while sck is low, then raises and lowers sck.
  task automatic drive_bit(input logic b);
    mosi = b;
    wait_clk(HALF);
    sck = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i]);
    end
  endtask

  task automatic frame_begin(input logic busy_exp);
    ss = 1'b0;
    wait_clk(4);
    check("busy_in_frame", {31'd0, rx_busy}, {31'd0, busy_exp});
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(3);
    check("busy_after_frame", {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic send_frame(input logic [15:0] v, input int n);
    frame_begin(1'b1);
    shift_bits(v, n);
    frame_end();
  endtask

  task automatic settle(input string tag);
    wait_clk(10);
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    check({tag, "_errs"}, err_seen, err_exp);
  endtask

  initial begin
    rst  = 1'b1;
    sck  = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Single word.
    exp_q.push_back(8'hA5);
    send_frame(16'h00A5, 8);
    settle("t1");

    // Two frames with a short ss-high gap.
    exp_q.push_back(8'h3C);
    send_frame(16'h003C, 8);
    exp_q.push_back(8'hC3);
    send_frame(16'h00C3, 8);
    settle("t2");

    // Two words in one ss window.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(16'h1234, 16);
    settle("t3");

    // Truncated frame: error pulse, rx_data holds, then a clean frame.
    send_frame(16'h0016, 5);
    err_exp++;
    settle("t4a");
    check("hold_after_err", {24'd0, rx_data}, 32'h34);
    exp_q.push_back(8'h81);
    send_frame(16'h0081, 8);
    settle("t4b");

    // Free-running sck with ss high.
    ss = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (sck == 1'b0) mosi = 1'($urandom_range(0, 1));
      sck = ~sck;
      wait_clk(HALF);
    end
    sck = 1'b0;
    settle("t5");

    // Reset mid-frame with ss still low.
    frame_begin(1'b1);
    shift_bits(16'h000B, 4);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    shift_bits(16'h0006, 4);
    check("rst_tail_busy", {31'd0, rx_busy}, 32'd0);
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(6);
    settle("t6a");
    exp_q.push_back(8'h5A);
    send_frame(16'h005A, 8);
    settle("t6b");
    check("final_rx_data", {24'd0, rx_data}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
